// File: rtl/ras_pkg.sv
// ras_pkg: shared types and constants for the return-address stack.
//   addr_t            - 16-bit return address
//   RAS_DEPTH_DEFAULT - default number of stack entries
//   ras_op_t          - per-cycle operation, encoded directly as {push,pop}
package ras_pkg;

    typedef logic [15:0] addr_t;

    localparam int RAS_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        RAS_NOP  = 2'b00,
        RAS_PUSH = 2'b10,
        RAS_POP  = 2'b01,
        RAS_REPL = 2'b11
    } ras_op_t;

endpackage

// File: rtl/ras_ptr_ctrl.sv
// ras_ptr_ctrl: stack pointer, entry count, status flags and sticky error.
//   clk, rst_n             - clock, async active-low reset
//   push_i, pop_i          - operation request, decoded as ras_op_t
//   err_clr_i              - synchronous clear of err_o (a new error wins)
//   we_o, widx_o           - storage write enable and slot
//   ridx_o                 - slot that becomes the top after a pop (sp-2)
//   pop_o, last_o          - a pop is taking effect / it empties the stack
//   depth_o, empty_o, full_o, err_o - registered status
// Macro RAS_OVF_WRAP_EN: push on full overwrites the oldest entry instead
// of being dropped with an error.
module ras_ptr_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     err_clr_i,
    output logic                     we_o,
    output logic [$clog2(DEPTH)-1:0] widx_o,
    output logic [$clog2(DEPTH)-1:0] ridx_o,
    output logic                     pop_o,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    ras_op_t         op;
    logic            is_push, push_ok, repl, pop_ok, unf, ovf_err;
    logic [PW-1:0]   sp_q, sp_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            empty_q, full_q, err_q, err_d;

    always_comb begin
        op      = ras_op_t'({push_i, pop_i});
        // a tail call on an empty stack has no top to replace, so it pushes
        is_push = op == RAS_PUSH || (op == RAS_REPL && empty_q);
        repl    = op == RAS_REPL && !empty_q;
`ifdef RAS_OVF_WRAP_EN
        push_ok = is_push;
        ovf_err = 1'b0;
`else
        push_ok = is_push && !full_q;
        ovf_err = is_push && full_q;
`endif
        pop_ok  = op == RAS_POP && !empty_q;
        unf     = op == RAS_POP && empty_q;
        sp_d    = push_ok ? sp_q + PW'(1) : pop_ok ? sp_q - PW'(1) : sp_q;
        // a wrapping push on full keeps depth at DEPTH
        depth_d = (push_ok && !full_q) ? depth_q + DW'(1) :
                  pop_ok ? depth_q - DW'(1) : depth_q;
        err_d   = (unf || ovf_err) ? 1'b1 : err_clr_i ? 1'b0 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            empty_q <= depth_d == '0;
            full_q  <= depth_d == DW'(DEPTH);
            err_q   <= err_d;
        end
    end

    assign we_o    = push_ok || repl;
    assign widx_o  = repl ? sp_q - PW'(1) : sp_q;
    assign ridx_o  = sp_q - PW'(2);
    assign pop_o   = pop_ok;
    assign last_o  = depth_q == DW'(1);
    assign depth_o = depth_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign err_o   = err_q;

endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: return-address stack for the call/return path.
//   clk, rst_n   - clock, async active-low reset
//   push         - call: push push_addr (PC+1)
//   push_addr    - return address to store
//   pop          - return: discard the top entry
//   err_clr      - clear the sticky err flag
//   top_addr     - registered current top entry, 0 when empty
//   empty, full, depth, err - registered status
// Macro RAS_OVF_WRAP_EN: circular overwrite on push when full.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int AW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [AW-1:0]          push_addr,
    input  logic                   pop,
    input  logic                   err_clr,
    output logic [AW-1:0]          top_addr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   err
);

    localparam int PW = $clog2(DEPTH);

    logic          we, pop_ok, last;
    logic [PW-1:0] widx, ridx;
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] top_q, top_d;

    ras_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .err_clr_i (err_clr),
        .we_o      (we),
        .widx_o    (widx),
        .ridx_o    (ridx),
        .pop_o     (pop_ok),
        .last_o    (last),
        .depth_o   (depth),
        .empty_o   (empty),
        .full_o    (full),
        .err_o     (err)
    );

    // storage needs no reset: only slots below sp are ever read
    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= push_addr;
    end

    // top_addr is kept as a shadow of mem[sp-1] so the consumer sees it
    // with no read latency in the cycle it pops
    always_comb begin
        top_d = we ? push_addr : pop_ok ? (last ? '0 : mem_q[ridx]) : top_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) top_q <= '0;
        else        top_q <= top_d;
    end

    assign top_addr = top_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: randomized and directed checks of return_addr_stack
// (DEPTH=4) against a queue-based reference model.
module tb_return_addr_stack;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] push_addr = '0;
    logic [15:0] top_addr;
    logic        empty, full, err;
    logic [2:0]  depth;

    logic [15:0] q[$];
    logic        m_err = 1'b0;
    int          checks = 0;
    int          failures = 0;

    return_addr_stack #(.DEPTH(DEPTH), .AW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .err_clr   (err_clr),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .depth     (depth),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".top"},   32'(top_addr), q.size() != 0 ? 32'(q[q.size()-1]) : 32'd0);
        check({tag, ".depth"}, 32'(depth),    32'(q.size()));
        check({tag, ".empty"}, 32'(empty),    32'(q.size() == 0));
        check({tag, ".full"},  32'(full),     32'(q.size() == DEPTH));
        check({tag, ".err"},   32'(err),      32'(m_err));
    endtask

    task automatic model(input logic p, input logic o, input logic [15:0] a, input logic c);
        logic e_set = 1'b0;
        if (p && (!o || q.size() == 0)) begin
            if (q.size() < DEPTH) q.push_back(a);
            else begin
`ifdef RAS_OVF_WRAP_EN
                void'(q.pop_front());
                q.push_back(a);
`else
                e_set = 1'b1;
`endif
            end
        end else if (p && o) q[q.size()-1] = a;
        else if (o) begin
            if (q.size() == 0) e_set = 1'b1;
            else void'(q.pop_back());
        end
        m_err = e_set ? 1'b1 : c ? 1'b0 : m_err;
    endtask

    task automatic step(input string tag, input logic p, input logic o, input logic [15:0] a, input logic c);
        push = p;
        pop = o;
        push_addr = a;
        err_clr = c;
        @(posedge clk);
        model(p, o, a, c);
        #1;
        push = 1'b0;
        pop = 1'b0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 0, 0, 16'h0, 0);
        step("push1", 1, 0, 16'h0011, 0);
        step("push2", 1, 0, 16'h0022, 0);
        step("push3", 1, 0, 16'h0033, 0);
        check("top_before_pop", 32'(top_addr), 32'h0033);
        step("pop1", 0, 1, 16'h0, 0);
        check("pop1_top", 32'(top_addr), 32'h0022);
        step("pop2", 0, 1, 16'h0, 0);
        step("pop3", 0, 1, 16'h0, 0);
        check("pop3_top", 32'(top_addr), 32'h0000);
        step("underflow", 0, 1, 16'h0, 0);
        check("underflow_err", 32'(err), 32'd1);
        step("err_clr", 0, 0, 16'h0, 1);
        for (int i = 0; i < 5; i++) step("ovf_push", 1, 0, 16'h0100 + 16'(i), 0);
`ifdef RAS_OVF_WRAP_EN
        check("ovf_top", 32'(top_addr), 32'h0104);
        check("ovf_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) step("wrap_pop", 0, 1, 16'h0, 0);
        step("wrap_unf", 0, 1, 16'h0, 0);
`else
        check("ovf_top", 32'(top_addr), 32'h0103);
        check("ovf_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 16'h0, 0);
`endif
        step("clr_set_race", 0, 1, 16'h0, 1);
        step("clr", 0, 0, 16'h0, 1);
        step("tc_push", 1, 0, 16'h0AAA, 0);
        step("tail_call", 1, 1, 16'h0BBB, 0);
        check("tail_top", 32'(top_addr), 32'h0BBB);
        step("tc_pop", 0, 1, 16'h0, 0);
        step("repl_empty", 1, 1, 16'h0CCC, 0);
        step("repl_empty_pop", 0, 1, 16'h0, 0);
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 9);
            step("rand", r < 4, r >= 3 && r < 8, 16'($urandom), r == 9);
        end
        step("ar_push1", 1, 0, 16'h1234, 0);
        step("ar_push2", 1, 0, 16'h5678, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_err = 1'b0;
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1, 0, 16'h4321, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack (RAS) for the 16-bit processor's call/return path.
- On a call, the PC-increment result (PC+1) is pushed.
- On a return, the most recent entry is popped and presented as the jump target.
- Sits between the PC increment path and the PC-select mux. Fully synchronous storage with registered status flags.

Parameters:
- DEPTH, 8, number of 16-bit entries; must be a power of two and at least 2.
- AW, 16, address/data width of each entry.

Ports:
- clk  input  1  processor clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  call: store push_addr as the new top.
- push_addr  input  AW  return address to store (PC+1).
- pop  input  1  return: discard the current top.
- err_clr  input  1  synchronous clear of the sticky err flag.
- top_addr  output  AW  current top entry, registered; 0 when empty.
- empty  output  1  registered; 1 when depth==0.
- full  output  1  registered; 1 when depth==DEPTH.
- depth  output  $clog2(DEPTH)+1  registered entry count.
- err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n low), regardless of any operation in progress:
  - depth=0, write pointer=0, top_addr=0, empty=1, full=0, err=0.
  - Storage array contents are don't-care.
  - Deassertion is assumed synchronous to clk upstream.
- Pointer: sp of width $clog2(DEPTH) indexes the next free slot. top = mem[sp-1], with modulo-DEPTH wrap.
- Operations are decoded per cycle from {push,pop}. All updates take effect at the rising edge. Outputs reflect the new state one cycle after the request (latency 1):
  - 00: hold.
  - 10 (push), not full: mem[sp]<=push_addr; sp<=sp+1; depth<=depth+1; top_addr<=push_addr.
  - 10, full: see Optional Feature.
  - 01 (pop), not empty: sp<=sp-1; depth<=depth-1; top_addr<=mem[sp-2], or 0 if the new depth is 0.
  - 01, empty: no state change; err<=1; top_addr stays 0.
  - 11 (tail call), not empty: replace the top entry. mem[sp-1]<=push_addr; top_addr<=push_addr; sp and depth unchanged; never overflows.
  - 11, empty: treated as push.
- Flag derivation: empty and full are derived from the next depth and registered, never combinational from the inputs.
- err:
  - Set by underflow, or by overflow when the wrap feature is off.
  - Cleared only by err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Consumer timing: the consumer samples top_addr in the same cycle it asserts pop, i.e. the value before the edge. top_addr therefore must always equal the current top entry.

Optional Feature:
- Macro: RAS_OVF_WRAP_EN.
- Defined (circular buffer):
  - A push on full overwrites the oldest entry: mem[sp]<=push_addr; sp<=sp+1; top_addr<=push_addr.
  - depth stays DEPTH, full stays 1, err is not set.
  - Subsequent pops return the newest DEPTH entries in LIFO order, then underflow.
- Undefined: a push on full is dropped (no state change except err<=1); top_addr unchanged.

Decomposition:
- Shared package (ras_pkg):
  - typedef addr_t (logic [15:0]);
  - localparam RAS_DEPTH_DEFAULT=8;
  - enum ras_op_t {RAS_NOP, RAS_PUSH, RAS_POP, RAS_REPL}, built from {push,pop}.
- One natural sub-module, ras_ptr_ctrl: owns sp, depth, the flags and err, and emits the write enable/index and read index.
- The top level holds the storage array and the top_addr register.

Test Plan (DEPTH=4):
- Reset then idle -> empty=1, full=0, depth=0, top_addr=0x0000, err=0.
- Push 0x0011, 0x0022, 0x0033; pop three times -> top_addr sequence 0x0033, 0x0022, 0x0011, 0x0000; empty=1 after the last pop; err=0.
- Pop on empty -> err=1 and state unchanged; then err_clr for 1 cycle -> err=0.
- Push 0x0100..0x0104 (five pushes):
  - Without macro: depth=4, full=1, err=1, top_addr=0x0103.
  - With macro: err=0, top_addr=0x0104; four pops yield 0x0104, 0x0103, 0x0102, 0x0101.
- Push 0x0AAA, then push=pop=1 with 0x0BBB -> depth=1, top_addr=0x0BBB; one pop -> empty.
- Push 0x1234 and 0x5678, assert rst_n=0 mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge.
